// File: rtl/pc_sel_if.sv
// pc_sel_if: fetch-PC select bundle between the pipeline and pc_sel_unit.
// master drives redirect/stall requests; slave returns the fetch PC.
interface pc_sel_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             jump;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic [31:0]      alu_target;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_plus4;
  logic             instr_valid;
  logic             flush;
  logic             misalign;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output stall, jump, branch_taken,
    output branch_target, alu_target,
    input  pc, pc_plus4, instr_valid,
    input  flush, misalign, redirect_cnt
  );

  modport slave (
    input  stall, jump, branch_taken,
    input  branch_target, alu_target,
    output pc, pc_plus4, instr_valid,
    output flush, misalign, redirect_cnt
  );
endinterface

// File: rtl/pc_sel_unit.sv
// pc_sel_unit: next-PC select with BOOT/RUN/BUBBLE sequencing.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets.
module pc_sel_unit #(
  parameter int PC_W     = 9,
  parameter int RESET_PC = 0,
  parameter int TRAP_PC  = 9'h100,
  parameter int CNT_W    = 16
) (
  input  logic      clk,
  input  logic      reset,
  pc_sel_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE
  } state_t;

  localparam logic [PC_W-1:0] RST_V =
    PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] TRAP_V =
    PC_W'(TRAP_PC);
  localparam logic [PC_W-1:0] ALIGN_M =
    {{(PC_W-2){1'b1}}, 2'b00};
  localparam logic [PC_W-1:0] HALF_M =
    {{(PC_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic [PC_W-1:0]  pc_q;
  logic             iv_q;
  logic             flush_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PC_W-1:0]  pc_nx4;
  logic [PC_W-1:0]  raw_tgt;
  logic [PC_W-1:0]  tgt;
  logic             redirect;
  logic             bad_align;
  logic             unused_alu;

  assign unused_alu = ^bus.alu_target;

  assign pc_nx4 = pc_q + PC_W'(4);

  assign redirect = (state != BOOT) &&
                    (bus.jump || bus.branch_taken);

  // jump wins over a simultaneous taken branch
  always_comb begin
    raw_tgt = bus.branch_target;
    if (bus.jump)
      raw_tgt = bus.alu_target[PC_W-1:0] & HALF_M;
  end

`ifdef PC_ALIGN_CHECK_EN
  assign bad_align = (raw_tgt[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  assign tgt = bad_align ? TRAP_V
                         : (raw_tgt & ALIGN_M);

  // state, PC and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= BOOT;
      pc_q    <= RST_V;
      iv_q    <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (redirect) begin
      state   <= BUBBLE;
      pc_q    <= tgt;
      iv_q    <= 1'b0;
      flush_q <= 1'b1;
      mis_q   <= bad_align;
      if (cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (!bus.stall) begin
      state   <= RUN;
      pc_q    <= pc_nx4;
      iv_q    <= 1'b1;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_nx4;
  assign bus.instr_valid  = iv_q;
  assign bus.flush        = flush_q;
  assign bus.misalign     = mis_q;
  assign bus.redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sel_unit.sv
// tb_pc_sel_unit: directed vector table plus counter saturation run.
// Expected values follow PC_ALIGN_CHECK_EN when it is defined.
module tb_pc_sel_unit;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rst2;

  always #5 clk = ~clk;

  pc_sel_if #(.PC_W(9), .CNT_W(16)) bus ();
  pc_sel_if #(.PC_W(9), .CNT_W(2))  bus2 ();

  pc_sel_unit #(
    .PC_W(9), .RESET_PC(0),
    .TRAP_PC(9'h100), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  pc_sel_unit #(
    .PC_W(9), .RESET_PC(0),
    .TRAP_PC(9'h100), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        jump;
    logic        br;
    logic [8:0]  btgt;
    logic [31:0] alu;
    logic [8:0]  pc;
    logic        iv;
    logic        fl;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t v(
    input logic rst, stall, jump, br,
    input logic [8:0] btgt,
    input logic [31:0] alu,
    input logic [8:0] pc,
    input logic iv, fl, mis,
    input logic [15:0] cnt
  );
    vec_t r;
    r.rst = rst; r.stall = stall;
    r.jump = jump; r.br = br;
    r.btgt = btgt; r.alu = alu;
    r.pc = pc; r.iv = iv; r.fl = fl;
    r.mis = mis; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rst2  = 1'b0;
    bus.stall = 0; bus.jump = 0;
    bus.branch_taken = 0;
    bus.branch_target = '0;
    bus.alu_target = '0;
    bus2.stall = 0; bus2.jump = 0;
    bus2.branch_taken = 0;
    bus2.branch_target = '0;
    bus2.alu_target = '0;

    // rst stl jmp br btgt alu | pc iv fl mis cnt
    vq.push_back(v(0,0,0,0,0,0,   9'h000,0,0,0,0));
    vq.push_back(v(1,0,0,0,0,0,   9'h004,1,0,0,0));
    vq.push_back(v(1,0,0,0,0,0,   9'h008,1,0,0,0));
    vq.push_back(v(1,0,0,1,9'h018,0,
                   9'h018,0,1,0,1));
    vq.push_back(v(1,0,0,0,0,0,   9'h01C,1,0,0,1));
    vq.push_back(v(1,0,1,1,9'h040,32'h0000000D,
                   9'h00C,0,1,0,2));
    vq.push_back(v(1,0,0,0,0,0,   9'h010,1,0,0,2));
    vq.push_back(v(1,0,1,0,0,32'h1FC,
                   9'h1FC,0,1,0,3));
    vq.push_back(v(1,0,0,0,0,0,   9'h000,1,0,0,3));
    vq.push_back(v(1,1,0,0,0,0,   9'h000,1,0,0,3));
    vq.push_back(v(1,1,0,0,0,0,   9'h000,1,0,0,3));
    vq.push_back(v(1,1,0,0,0,0,   9'h000,1,0,0,3));
    vq.push_back(v(1,1,1,0,0,32'h20,
                   9'h020,0,1,0,4));
    vq.push_back(v(1,0,0,1,9'h030,0,
                   9'h030,0,1,0,5));
    vq.push_back(v(1,0,0,1,9'h01A,0,
                   CHK ? 9'h100 : 9'h018,0,1,CHK,6));
    vq.push_back(v(1,0,0,0,0,0,
                   CHK ? 9'h104 : 9'h01C,1,0,0,6));
    vq.push_back(v(1,0,1,0,0,32'h207,
                   CHK ? 9'h100 : 9'h004,0,1,CHK,7));
    vq.push_back(v(1,0,0,0,0,0,
                   CHK ? 9'h104 : 9'h008,1,0,0,7));
    vq.push_back(v(1,0,1,0,0,32'h80,
                   9'h080,0,1,0,8));
    vq.push_back(v(0,0,1,0,0,32'h40,
                   9'h000,0,0,0,0));
    vq.push_back(v(1,0,1,1,9'h040,32'h40,
                   9'h004,1,0,0,0));
    vq.push_back(v(1,1,0,0,0,0,   9'h004,1,0,0,0));
    vq.push_back(v(1,0,0,0,0,0,   9'h008,1,0,0,0));
    vq.push_back(v(0,0,0,0,0,0,   9'h000,0,0,0,0));
    vq.push_back(v(1,1,0,0,0,0,   9'h000,0,0,0,0));
    vq.push_back(v(1,0,0,0,0,0,   9'h004,1,0,0,0));

    foreach (vq[i]) begin
      reset             = vq[i].rst;
      bus.stall         = vq[i].stall;
      bus.jump          = vq[i].jump;
      bus.branch_taken  = vq[i].br;
      bus.branch_target = vq[i].btgt;
      bus.alu_target    = vq[i].alu;
      step();
      chk($sformatf("v%0d_pc", i),
          32'(bus.pc), 32'(vq[i].pc));
      chk($sformatf("v%0d_pc4", i),
          32'(bus.pc_plus4),
          32'(9'(vq[i].pc + 9'd4)));
      chk($sformatf("v%0d_iv", i),
          32'(bus.instr_valid), 32'(vq[i].iv));
      chk($sformatf("v%0d_flush", i),
          32'(bus.flush), 32'(vq[i].fl));
      chk($sformatf("v%0d_mis", i),
          32'(bus.misalign), 32'(vq[i].mis));
      chk($sformatf("v%0d_cnt", i),
          32'(bus.redirect_cnt), 32'(vq[i].cnt));
    end

    rst2 = 1'b0;
    step();
    chk("sat_rst_cnt", 32'(bus2.redirect_cnt), 0);
    rst2 = 1'b1;
    step();
    chk("sat_boot_iv", 32'(bus2.instr_valid), 1);
    bus2.jump = 1'b1;
    bus2.alu_target = 32'h40;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("sat_cnt%0d", k),
          32'(bus2.redirect_cnt),
          (k > 3) ? 32'd3 : 32'(k));
      chk($sformatf("sat_fl%0d", k),
          32'(bus2.flush), 1);
      chk($sformatf("sat_iv%0d", k),
          32'(bus2.instr_valid), 0);
    end
    bus2.jump = 1'b0;
    step();
    chk("sat_end_fl", 32'(bus2.flush), 0);
    chk("sat_end_cnt", 32'(bus2.redirect_cnt), 3);
    chk("sat_end_pc", 32'(bus2.pc), 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sel_unit.md
PC_SEL_UNIT -- requirements
Module: pc_sel_unit

Interface
- REQ-001: Parameter PC_W, default 9: program-counter width in bits; legal range 4..32.
- REQ-002: Parameter RESET_PC, default 0: PC value loaded at reset; bits [1:0] are 00.
- REQ-003: Parameter TRAP_PC, default 9'h100: PC loaded on a misaligned redirect; bits [1:0] are 00.
- REQ-004: Parameter CNT_W, default 16: width of the redirect counter.
- REQ-005: clk  in  1  sole clock; all state updates on its rising edge.
- REQ-006: reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- REQ-007: stall  in  1  hold the PC and state.
- REQ-008: jump  in  1  JAL/JALR redirect request.
- REQ-009: branch_taken  in  1  resolved taken-branch request.
- REQ-010: branch_target  in  PC_W  branch target address.
- REQ-011: alu_target  in  32  jump target from the ALU.
- REQ-012: pc  out  PC_W  current fetch address.
- REQ-013: pc_plus4  out  PC_W  combinational pc+4, modulo 2^PC_W.
- REQ-014: instr_valid  out  1  fetch at pc is architecturally valid.
- REQ-015: flush  out  1  squash younger instructions.
- REQ-016: misalign  out  1  one-cycle misaligned-target pulse.
- REQ-017: redirect_cnt  out  CNT_W  saturating count of accepted redirects.

Function
- REQ-018: Next-PC priority: jump > branch_taken > pc_plus4. Jump target = alu_target[PC_W-1:0] with bit 0 cleared. Branch target = branch_target.
- REQ-019: States: BOOT, RUN, BUBBLE. BOOT lasts one cycle after reset release, with instr_valid=0, and then moves to RUN.
- REQ-020: In RUN with no redirect and stall=0: pc <= pc_plus4. pc+4 wraps, so PC_W=9 gives 0x1FC -> 0x000.
- REQ-021: An accepted redirect is jump or branch_taken in RUN or BUBBLE. It loads the target the next cycle, asserts flush for exactly that one cycle, and moves to BUBBLE.
- REQ-022: In BUBBLE: instr_valid=0 and pc <= pc_plus4 if there is no redirect. The unit then returns to RUN.
- REQ-023: Redirect overrides stall. Otherwise, stall=1 holds pc, state and all outputs except pc_plus4.
- REQ-024: In BOOT, jump and branch_taken are ignored.
- REQ-025: In RUN, instr_valid=1.
- REQ-026: redirect_cnt increments by 1 per accepted redirect. It saturates at 2^CNT_W-1 and does not wrap.
- REQ-027: Simultaneous jump and branch_taken count as one redirect, which takes the jump target.
- REQ-028: Back-to-back redirects in consecutive cycles are each accepted. Flush stays high on each of those cycles, and the state remains BUBBLE.

Reset
- REQ-029: While reset=0 at a rising edge, the following SHALL take effect on that edge: pc=RESET_PC, state=BOOT, instr_valid=0, flush=0, misalign=0, redirect_cnt=0.
- REQ-030: Reset SHALL override stall, jump and branch_taken, including when it arrives mid-BUBBLE.

Configuration
- REQ-031: Macro PC_ALIGN_CHECK_EN controls misaligned-target checking.
- REQ-032: With PC_ALIGN_CHECK_EN defined, an accepted redirect whose target has bits [1:0] != 00 SHALL:
  - load TRAP_PC instead of the target;
  - pulse misalign for one cycle, concurrent with flush;
  - still count in redirect_cnt.
- REQ-033: Without PC_ALIGN_CHECK_EN, target bits [1:0] SHALL be forced to 00 and misalign SHALL be tied to 0.

Verification
- REQ-034: Reset, then 4 free cycles -> pc 0x000 (instr_valid=0), 0x004, 0x008, 0x00C, each with instr_valid=1.
- REQ-035: At pc=0x008, branch_taken=1 with branch_target=0x018 -> next pc=0x018 with flush=1 and instr_valid=0; the cycle after that, pc=0x01C and instr_valid=1; redirect_cnt=1.
- REQ-036: jump=1 with alu_target=0x0000000D and branch_taken=1 with branch_target=0x040 in the same cycle -> next pc=0x00C; redirect_cnt increments by exactly 1.
- REQ-037: pc=0x1FC, free run -> pc=0x000. Then stall=1 for 3 cycles -> pc stays 0x000. Then stall=1 with jump=1 and alu_target=0x20 -> pc=0x020.
- REQ-038: With PC_ALIGN_CHECK_EN defined, branch_target=0x01A taken -> pc=0x100, misalign=1 for one cycle, flush=1. Without the macro, the same stimulus -> pc=0x018 and misalign=0.
- REQ-039: Assert reset=0 during BUBBLE with jump=1 -> next pc=RESET_PC, flush=0, redirect_cnt=0.
